// File: rtl/slot_pkg.sv
// Shared slot machine definitions: spin FSM states, digit width,
// jackpot digit, LFSR taps and small digit helpers.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN1,
        SPIN2,
        SPIN3,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] JACKPOT_DIGIT = 4'd7;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fold a raw nibble into 0..dmax by subtracting (dmax+1) once
    function automatic logic [DIGIT_W-1:0] reduce_digit(
        input logic [DIGIT_W-1:0] n,
        input logic [DIGIT_W-1:0] dmax
    );
        if (n > dmax) begin
            return n - dmax - DIGIT_W'(1);
        end
        return n;
    endfunction

    // Advance a spinning reel, wrapping dmax back to 0
    function automatic logic [DIGIT_W-1:0] next_digit(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] dmax
    );
        if (d == dmax) begin
            return '0;
        end
        return d + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the reel stop source.
// Steps every cycle; reset loads the seed.
module lfsr16
    import slot_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] Q
);

    logic feedback;

    assign feedback = ^(Q & LFSR_TAPS);

    // Shift left, feeding the tap parity into bit 0
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= LFSR_SEED;
        end else begin
            Q <= {Q[14:0], feedback};
        end
    end

endmodule

// File: rtl/reel_spinner.sv
// Spin stage: animates three reels, stops them left to right and
// hands the final 12-bit result to the win stage with a done pulse.
module reel_spinner
    import slot_pkg::*;
#(
    parameter int          DIGIT_MAX   = 9,
    parameter int          SPIN_CYCLES = 8,
    parameter int          TICK_DIV    = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        BetIn,
    input  logic        RigEn,
    input  logic [11:0] RigValue,
    output logic [11:0] ReelDigits,
    output logic [11:0] PlayerSpin,
    output logic        PlayerBet,
    output logic        SpinBusy,
    output logic        SpinDone
);

    localparam int SCW = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SCW-1:0] STAGE_LAST = SCW'(SPIN_CYCLES - 1);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

    state_t state;
    state_t next_state;

    logic [SCW-1:0] stage_cnt;
    logic [TW-1:0]  tick_cnt;
    logic           stage_end;
    logic           spinning;
    logic           step;
    logic           accept;

    logic           rig_en_q;
    logic [11:0]    rig_q;

    logic [DIGIT_W-1:0] reel0;
    logic [DIGIT_W-1:0] reel1;
    logic [DIGIT_W-1:0] reel2;
    logic [DIGIT_W-1:0] stop0;
    logic [DIGIT_W-1:0] stop1;
    logic [DIGIT_W-1:0] stop2;
    logic [DIGIT_W-1:0] rnd_digit;

    logic           busy_d;
    logic           done_d;

    logic [15:0]    lfsr_q;
    logic           lfsr_unused;

    lfsr16 #(
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .Clock(Clock),
        .Reset(Reset),
        .Q    (lfsr_q)
    );

    // Only the low nibble picks stop digits
    assign lfsr_unused = ^lfsr_q[15:4];

    assign spinning  = (state == SPIN1) || (state == SPIN2) ||
                       (state == SPIN3);
    assign stage_end = spinning && (stage_cnt == STAGE_LAST);
    assign step      = spinning && (tick_cnt == TICK_LAST);
    assign accept    = (state == IDLE) && Start;

    assign rnd_digit = reduce_digit(lfsr_q[3:0], DMAX);
    assign stop0 = rig_en_q ? reduce_digit(rig_q[11:8], DMAX) : rnd_digit;
    assign stop1 = rig_en_q ? reduce_digit(rig_q[7:4], DMAX) : rnd_digit;
    assign stop2 = rig_en_q ? reduce_digit(rig_q[3:0], DMAX) : rnd_digit;

    assign ReelDigits = {reel0, reel1, reel2};

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: each spin stage lasts SPIN_CYCLES, DONE lasts one
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (Start) next_state = SPIN1;
            SPIN1:   if (stage_end) next_state = SPIN2;
            SPIN2:   if (stage_end) next_state = SPIN3;
            SPIN3:   if (stage_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status decode of the upcoming state, registered below
    always_comb begin
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
    end

    // Registered status flags
    always_ff @(posedge Clock) begin
        if (Reset) begin
            SpinBusy <= 1'b0;
            SpinDone <= 1'b0;
        end else begin
            SpinBusy <= busy_d;
            SpinDone <= done_d;
        end
    end

    // Stage and animation tick counters, cleared on accepted start
    always_ff @(posedge Clock) begin
        if (Reset || accept || !spinning) begin
            stage_cnt <= '0;
            tick_cnt  <= '0;
        end else begin
            stage_cnt <= stage_end ? '0 : stage_cnt + SCW'(1);
            tick_cnt  <= step ? '0 : tick_cnt + TW'(1);
        end
    end

    // Latch bet and rig request on accepted start
    always_ff @(posedge Clock) begin
        if (Reset) begin
            PlayerBet <= 1'b0;
            rig_en_q  <= 1'b0;
            rig_q     <= '0;
        end else if (accept) begin
            PlayerBet <= BetIn;
            rig_en_q  <= RigEn;
            rig_q     <= RigValue;
        end
    end

    // Reels spin on tick wraps and freeze as their stage ends
    always_ff @(posedge Clock) begin
        if (Reset) begin
            reel0 <= '0;
            reel1 <= '0;
            reel2 <= '0;
        end else begin
            unique case (state)
                SPIN1: begin
                    if (stage_end) reel0 <= stop0;
                    else if (step) reel0 <= next_digit(reel0, DMAX);
                    if (step) reel1 <= next_digit(reel1, DMAX);
                    if (step) reel2 <= next_digit(reel2, DMAX);
                end
                SPIN2: begin
                    if (stage_end) reel1 <= stop1;
                    else if (step) reel1 <= next_digit(reel1, DMAX);
                    if (step) reel2 <= next_digit(reel2, DMAX);
                end
                SPIN3: begin
                    if (stage_end) reel2 <= stop2;
                    else if (step) reel2 <= next_digit(reel2, DMAX);
                end
                default: begin
                end
            endcase
        end
    end

    // Final result is captured as the last reel stops
    always_ff @(posedge Clock) begin
        if (Reset) begin
            PlayerSpin <= '0;
        end else if ((state == SPIN3) && stage_end) begin
            PlayerSpin <= {reel0, reel1, stop2};
        end
    end

endmodule

// File: tb/tb_reel_spinner.sv
// Scoreboard bench for reel_spinner: stimulus queues expected done
// events, a negedge monitor pops and compares them.
module tb_reel_spinner;

    logic        clk;
    logic        rst;
    logic        start;
    logic        bet_in;
    logic        rig_en;
    logic [11:0] rig_value;
    logic [11:0] reel_digits;
    logic [11:0] player_spin;
    logic        player_bet;
    logic        spin_busy;
    logic        spin_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] spin;
        logic        bet;
        int          cyc;
        bit          known;
    } exp_t;

    exp_t sb[$];

    reel_spinner dut (
        .Clock     (clk),
        .Reset     (rst),
        .Start     (start),
        .BetIn     (bet_in),
        .RigEn     (rig_en),
        .RigValue  (rig_value),
        .ReelDigits(reel_digits),
        .PlayerSpin(player_spin),
        .PlayerBet (player_bet),
        .SpinBusy  (spin_busy),
        .SpinDone  (spin_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h",
                     name, cyc, act, exp);
        end
    endtask

    // Move to just after the rising edge that begins cycle c
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample point in the middle of cycle c
    task automatic sample_at(input int c);
        go(c);
        @(negedge clk);
    endtask

    task automatic start_spin(input logic rig, input logic [11:0] val,
                              input logic bet, input logic [11:0] exp,
                              input bit known, input bit push,
                              output int t);
        go(cyc + 1);
        t = cyc;
        start = 1'b1;
        rig_en = rig;
        rig_value = val;
        bet_in = bet;
        if (push) sb.push_back('{exp, bet, t + 25, known});
        go(t + 1);
        start = 1'b0;
        rig_en = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (spin_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle=%0d spin=%0h",
                         cyc, player_spin);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_bet", {31'd0, player_bet}, {31'd0, e.bet});
                chk("spin_eq_reels", {20'd0, player_spin},
                    {20'd0, reel_digits});
                chk("digit_range",
                    {31'd0, (player_spin[11:8] <= 4'd9) &&
                            (player_spin[7:4] <= 4'd9) &&
                            (player_spin[3:0] <= 4'd9)}, 32'd1);
                if (e.known)
                    chk("done_spin", {20'd0, player_spin},
                        {20'd0, e.spin});
            end
        end
    end

    initial begin
        int t;
        logic [3:0] r0;
        logic [3:0] r1;
        logic [11:0] hold;

        rst = 1'b1;
        start = 1'b0;
        bet_in = 1'b0;
        rig_en = 1'b0;
        rig_value = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_reels", {20'd0, reel_digits}, 32'd0);
        chk("rst_spin", {20'd0, player_spin}, 32'd0);
        chk("rst_bet", {31'd0, player_bet}, 32'd0);
        chk("rst_busy", {31'd0, spin_busy}, 32'd0);
        chk("rst_done", {31'd0, spin_done}, 32'd0);

        // Jackpot rig with a rejected second start mid-spin
        start_spin(1'b1, 12'h777, 1'b1, 12'h777, 1'b1, 1'b1, t);
        sample_at(t + 1);
        chk("busy_t1", {31'd0, spin_busy}, 32'd1);
        go(t + 5);
        start = 1'b1;
        bet_in = 1'b0;
        go(t + 6);
        start = 1'b0;
        sample_at(t + 25);
        chk("busy_t25", {31'd0, spin_busy}, 32'd1);
        sample_at(t + 26);
        chk("busy_t26", {31'd0, spin_busy}, 32'd0);
        chk("jack_bet", {31'd0, player_bet}, 32'd1);
        chk("jack_spin", {20'd0, player_spin}, 32'h777);

        // Rig nibble reduction
        start_spin(1'b1, 12'h3A5, 1'b0, 12'h305, 1'b1, 1'b1, t);
        sample_at(t + 26);
        chk("rig_red_spin", {20'd0, player_spin}, 32'h305);
        chk("rig_red_bet", {31'd0, player_bet}, 32'd0);

        // Reset in the middle of a spin
        start_spin(1'b1, 12'h777, 1'b1, 12'h0, 1'b0, 1'b0, t);
        go(t + 10);
        rst = 1'b1;
        go(t + 11);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_reels", {20'd0, reel_digits}, 32'd0);
        chk("mid_rst_spin", {20'd0, player_spin}, 32'd0);
        chk("mid_rst_bet", {31'd0, player_bet}, 32'd0);
        chk("mid_rst_busy", {31'd0, spin_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, spin_done}, 32'd0);
        start_spin(1'b1, 12'h129, 1'b1, 12'h129, 1'b1, 1'b1, t);
        sample_at(t + 26);
        chk("post_rst_busy", {31'd0, spin_busy}, 32'd0);
        chk("post_rst_spin", {20'd0, player_spin}, 32'h129);

        // Random soak, reels freeze left to right
        for (int i = 0; i < 200; i++) begin
            start_spin(1'b0, 12'($urandom),
                       1'($urandom_range(0, 1)),
                       12'h0, 1'b0, 1'b1, t);
            sample_at(t + 9);
            r0 = reel_digits[11:8];
            sample_at(t + 17);
            r1 = reel_digits[7:4];
            chk("soak_r0_t17", {28'd0, reel_digits[11:8]}, {28'd0, r0});
            sample_at(t + 25);
            chk("soak_r0_hold", {28'd0, reel_digits[11:8]}, {28'd0, r0});
            chk("soak_r1_hold", {28'd0, reel_digits[7:4]}, {28'd0, r1});
        end

        // Back-to-back with Start held high
        go(cyc + 1);
        t = cyc;
        start = 1'b1;
        bet_in = 1'b1;
        rig_en = 1'b0;
        sb.push_back('{12'h0, 1'b1, t + 25, 1'b0});
        sb.push_back('{12'h0, 1'b1, t + 51, 1'b0});
        sb.push_back('{12'h0, 1'b1, t + 77, 1'b0});
        sample_at(t + 25);
        hold = player_spin;
        sample_at(t + 40);
        chk("b2b_hold_a", {20'd0, player_spin}, {20'd0, hold});
        sample_at(t + 50);
        chk("b2b_hold_b", {20'd0, player_spin}, {20'd0, hold});
        sample_at(t + 51);
        hold = player_spin;
        go(t + 53);
        start = 1'b0;
        sample_at(t + 70);
        chk("b2b_hold_c", {20'd0, player_spin}, {20'd0, hold});
        sample_at(t + 80);
        chk("b2b_idle", {31'd0, spin_busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
